afifo_rd_packer: RTL and testbench
==================================

AFIFO_RD_PACKER -- requirements
Module: afifo_rd_packer

Interface
REQ-001 Width, default 8, byte width of the FIFO read data.
REQ-002 Lanes, default 4, number of FIFO entries packed per output word.
REQ-003 RDclk  input  1  single clock; reset is synchronous and active-high; all logic updates on the RDclk rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 FIFOempty  input  1  empty flag from the upstream asynchronous FIFO read port.
REQ-006 RDdata  input  Width  FIFO read data; valid in the cycle after an accepted read.
REQ-007 RDreq  output  1  FIFO read request.
REQ-008 flush  input  1  level request to emit the partial word currently held.
REQ-009 OutData  output  Width*Lanes  packed word; first-read byte sits in bits [Width-1:0].
REQ-010 OutValid  output  1  OutData/OutCount valid.
REQ-011 OutReady  input  1  downstream accept; the word transfers when OutValid && OutReady.
REQ-012 OutCount  output  clog2(Lanes)+1  number of valid lanes in OutData (1..Lanes).

Function
REQ-013 An accepted read is a cycle with RDreq=1 and FIFOempty=0; its byte is sampled from RDdata at the next rising edge.
REQ-014 Internal state: lane counter cnt (0..Lanes), pending-read flag pend, state in {FILL, HOLD}.
REQ-015 RDreq = !FIFOempty && state==FILL && !flush && (cnt + pend) < Lanes, combinational.
REQ-016 A sampled byte goes into lane cnt, then cnt increments; lane order is strictly the FIFO read order, and FIFOempty bubbles insert no gaps.
REQ-017 Sustained throughput is one byte per cycle while the FIFO is non-empty in FILL.
REQ-018 When cnt reaches Lanes, state moves to HOLD at that edge: OutValid=1, OutCount=Lanes.
REQ-019 Latency: with RDreq high in cycles 0..3, OutValid is first high in cycle 5.
REQ-020 In HOLD, OutData and OutCount stay stable, and RDreq=0, until the handshake occurs.
REQ-021 On handshake: OutValid=0, cnt=0, state=FILL at the same edge; reads resume in the next cycle.
REQ-022 Flush: in FILL with flush=1, pend=0 and cnt>0, the block enters HOLD with OutCount=cnt and unused lanes zero.
REQ-023 Flush with pend=1 waits until the pending byte is captured, then applies REQ-022 (RDreq is already blocked by flush).
REQ-024 Flush with cnt=0 and pend=0 has no effect; flush in HOLD has no effect.
REQ-025 Capture of the last lane and flush in the same cycle produces a full word with OutCount=Lanes.
REQ-026 FIFOempty is never ignored: RDreq never asserts while FIFOempty=1.

Reset
REQ-027 While reset=1: RDreq=0, OutValid=0, OutData=0, OutCount=0, cnt=0, pend=0, state=FILL.
REQ-028 Reset takes priority over every other input, including a handshake or flush in the same cycle.
REQ-029 A byte returned for a read issued before reset is discarded.
REQ-030 The first RDreq may assert in the first cycle after reset deasserts.

Verification
REQ-031 Assert reset for 2 cycles -> all outputs 0; RDreq=0 even with FIFOempty=0.
REQ-032 FIFO holds 01,02,03,04, OutReady=1 -> OutData=32'h04030201, OutCount=4, OutValid high for exactly one cycle, first high 5 cycles after the first RDreq.
REQ-033 FIFO holds 05..0C, OutReady low for 10 cycles -> OutData held at 32'h08070605 with RDreq=0; after OutReady rises, the next word is 32'h0C0B0A09.
REQ-034 FIFO holds 11,12,13 then goes empty; pulse flush -> OutData=32'h00131211, OutCount=3.
REQ-035 FIFOempty toggles every other cycle while 21..28 stream in -> words 32'h24232221 and 32'h28272625, with no loss or reordering.
REQ-036 Reset asserted with cnt=2 and a read pending -> after reset, the next word is built only from post-reset bytes.

Source files
------------

// File: rtl/afifo_rd_packer.sv
// Packs bytes read from an asynchronous FIFO's read port into Lanes-wide words,
// with a level-sensitive flush that emits a partially filled word.
module afifo_rd_packer #(
    parameter int Width = 8,
    parameter int Lanes = 4
) (
    input  logic                     RDclk,
    input  logic                     reset,
    input  logic                     FIFOempty,
    input  logic [Width-1:0]         RDdata,
    output logic                     RDreq,
    input  logic                     flush,
    output logic [Width*Lanes-1:0]   OutData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [$clog2(Lanes):0]   OutCount,
    output logic                     dbg_hold
);

    localparam int CW = $clog2(Lanes) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(Lanes);
    localparam logic [CW:0]   OCC_FULL = (CW+1)'(Lanes);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [Width*Lanes-1:0]   data_q, data_d;
    logic [CW:0]              occ;
    logic                     rd_req;

    // Output handshake: OutValid rises with a complete or flushed word and stays
    // high, with OutData/OutCount stable, until a cycle with OutValid && OutReady;
    // the word transfers at that rising edge and the lane counter restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        occ     = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
        // Lanes already filled plus the one in flight must leave room for another read.
        rd_req  = !reset && !FIFOempty && (state_q == FILL) && !flush && (occ < OCC_FULL);
        pend_d  = rd_req;

        case (state_q)
            FILL: begin
                if (pend_q) begin
                    for (int i = 0; i < Lanes; i++) begin
                        if (cnt_q == CW'(i)) begin
                            data_d[i*Width +: Width] = RDdata;
                        end
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_d == CNT_FULL) begin
                    state_d = HOLD;
                end else if (flush && !pend_q && (cnt_q != '0)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge RDclk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
        end
    end

    assign RDreq    = rd_req;
    assign OutValid = (state_q == HOLD) && !reset;
    assign OutData  = OutValid ? data_q : '0;
    assign OutCount = OutValid ? cnt_q : '0;
    assign dbg_hold = (state_q == HOLD);

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Directed bench for afifo_rd_packer: a queue-backed FIFO read-port model feeds
// the packer, and every word is compared against hand-computed values.
module tb_afifo_rd_packer;

    logic        RDclk;
    logic        reset;
    logic        FIFOempty;
    logic [7:0]  RDdata;
    logic        RDreq;
    logic        flush;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  OutCount;
    logic        dbg_hold;

    afifo_rd_packer #(.Width(8), .Lanes(4)) dut (
        .RDclk    (RDclk),
        .reset    (reset),
        .FIFOempty(FIFOempty),
        .RDdata   (RDdata),
        .RDreq    (RDreq),
        .flush    (flush),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutCount (OutCount),
        .dbg_hold (dbg_hold)
    );

    // clock / reset
    initial RDclk = 1'b0;
    always #5 RDclk = ~RDclk;

    logic [7:0] fifo_q[$];
    logic [7:0] next_data;
    logic       stall;
    logic       toggle_en;
    logic       last_rd;
    int         n_checks;
    int         n_pass;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs settle at the falling edge, outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(negedge RDclk);
        RDdata    = next_data;
        next_data = 8'hEE;
        if (toggle_en) stall = ~stall;
        FIFOempty = (fifo_q.size() == 0) || stall;
        #1;
        last_rd = RDreq;
        if (FIFOempty) check_val("rdreq_while_empty", {63'd0, RDreq}, 64'd0);
        if (RDreq && !FIFOempty) next_data = fifo_q.pop_front();
        @(posedge RDclk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!OutValid && n < 40) begin
            tick();
            n++;
        end
        if (!OutValid) check_val("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_word(input string tag, input logic [31:0] exp_data, input logic [2:0] exp_cnt);
        int n;
        OutReady = 1'b1;
        wait_valid(n);
        check_val({tag, "_data"}, {32'd0, OutData}, {32'd0, exp_data});
        check_val({tag, "_count"}, {61'd0, OutCount}, {61'd0, exp_cnt});
        tick();
        check_val({tag, "_valid_drop"}, {63'd0, OutValid}, 64'd0);
    endtask

    task automatic push_bytes(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(first + 8'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        FIFOempty = 1'b1;
        RDdata    = 8'h00;
        flush     = 1'b0;
        OutReady  = 1'b0;
        next_data = 8'hEE;
        stall     = 1'b0;
        toggle_en = 1'b0;
        last_rd   = 1'b0;

        // reset with a non-empty FIFO: nothing is requested, all outputs zero
        fifo_q.push_back(8'hAA);
        tick();
        tick();
        check_val("rst_rdreq_cycle", {63'd0, last_rd}, 64'd0);
        check_val("rst_rdreq_now", {63'd0, RDreq}, 64'd0);
        check_val("rst_valid", {63'd0, OutValid}, 64'd0);
        check_val("rst_data", {32'd0, OutData}, 64'd0);
        check_val("rst_count", {61'd0, OutCount}, 64'd0);
        fifo_q.delete();
        reset = 1'b0;

        // single full word: latency and one-cycle valid
        push_bytes(8'h01, 4);
        OutReady = 1'b1;
        tick();
        check_val("first_rdreq", {63'd0, last_rd}, 64'd1);
        n = 1;
        while (!OutValid && n < 40) begin
            tick();
            n++;
        end
        check_val("latency_cycles", 64'(n), 64'd5);
        check_val("w1_data", {32'd0, OutData}, 64'h04030201);
        check_val("w1_count", {61'd0, OutCount}, 64'd4);
        tick();
        check_val("w1_one_cycle", {63'd0, OutValid}, 64'd0);

        // back-pressure: word held stable, no reads while held
        OutReady = 1'b0;
        push_bytes(8'h05, 8);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_data", {32'd0, OutData}, 64'h08070605);
            check_val("hold_rdreq", {63'd0, last_rd}, 64'd0);
            check_val("hold_valid", {63'd0, OutValid}, 64'd1);
        end
        check_val("hold_count", {61'd0, OutCount}, 64'd4);
        OutReady = 1'b1;
        tick();
        check_val("hold_release", {63'd0, OutValid}, 64'd0);
        wait_word("w3", 32'h0C0B0A09, 3'd4);

        // partial word flushed
        push_bytes(8'h11, 3);
        repeat (6) tick();
        check_val("partial_no_valid", {63'd0, OutValid}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_valid", {63'd0, OutValid}, 64'd1);
        check_val("flush_data", {32'd0, OutData}, 64'h00131211);
        check_val("flush_count", {61'd0, OutCount}, 64'd3);
        tick();
        check_val("flush_done", {63'd0, OutValid}, 64'd0);

        // flush with nothing held does nothing
        flush = 1'b1;
        tick();
        check_val("flush_empty", {63'd0, OutValid}, 64'd0);
        flush = 1'b0;

        // flush with a read in flight waits for that byte
        push_bytes(8'h31, 2);
        tick();
        flush = 1'b1;
        tick();
        check_val("flush_pend_rdreq", {63'd0, last_rd}, 64'd0);
        check_val("flush_pend_wait", {63'd0, OutValid}, 64'd0);
        tick();
        check_val("flush_pend_valid", {63'd0, OutValid}, 64'd1);
        check_val("flush_pend_data", {32'd0, OutData}, 64'h00000031);
        check_val("flush_pend_count", {61'd0, OutCount}, 64'd1);
        flush = 1'b0;
        tick();
        repeat (3) tick();
        flush = 1'b1;
        wait_word("w_32", 32'h00000032, 3'd1);
        flush = 1'b0;

        // flush on the cycle the last lane lands gives a full word
        push_bytes(8'h41, 4);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_full_valid", {63'd0, OutValid}, 64'd1);
        check_val("flush_full_data", {32'd0, OutData}, 64'h44434241);
        check_val("flush_full_count", {61'd0, OutCount}, 64'd4);
        tick();

        // FIFOempty bubbles every other cycle
        toggle_en = 1'b1;
        push_bytes(8'h21, 8);
        wait_word("bubble_a", 32'h24232221, 3'd4);
        wait_word("bubble_b", 32'h28272625, 3'd4);
        toggle_en = 1'b0;
        stall     = 1'b0;

        // reset mid-word with a read in flight
        push_bytes(8'h51, 5);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        tick();
        check_val("midrst_valid", {63'd0, OutValid}, 64'd0);
        reset = 1'b0;
        push_bytes(8'h61, 2);
        wait_word("post_rst", 32'h62615554, 3'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
